// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: single-beat AXI4-Lite channel bundle (AR/R/AW/W/B, no IDs)
interface axi_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  ar_valid;
  logic [ADDR_W-1:0]     ar_addr;
  logic                  ar_ready;

  logic                  r_valid;
  logic [DATA_W-1:0]     r_data;
  logic [1:0]            r_resp;
  logic                  r_ready;

  logic                  aw_valid;
  logic [ADDR_W-1:0]     aw_addr;
  logic                  aw_ready;

  logic                  w_valid;
  logic [DATA_W-1:0]     w_data;
  logic [DATA_W/8-1:0]   w_strb;
  logic                  w_ready;

  logic                  b_valid;
  logic [1:0]            b_resp;
  logic                  b_ready;

  modport master (
    output ar_valid, ar_addr, input ar_ready,
    input  r_valid, r_data, r_resp, output r_ready,
    output aw_valid, aw_addr, input aw_ready,
    output w_valid, w_data, w_strb, input w_ready,
    input  b_valid, b_resp, output b_ready
  );

  modport slave (
    input  ar_valid, ar_addr, output ar_ready,
    output r_valid, r_data, r_resp, input r_ready,
    input  aw_valid, aw_addr, output aw_ready,
    input  w_valid, w_data, w_strb, output w_ready,
    output b_valid, b_resp, input b_ready
  );

endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4-Lite responder backed by a word-addressed SRAM with
// fixed, programmable read and write latencies. Reads and writes run in
// independent FSMs; a read sampling the same word on the write-commit edge
// sees the old contents.
module axi_sram_slave #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h8000_0000),
  parameter int                RD_LAT     = 2,
  parameter int                WR_LAT     = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  axi_sram_slave_if.slave bus
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int WORDS   = 1 << DEPTH_LOG2;
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (MAX_LAT == 0) ? 1 : $clog2(MAX_LAT + 1);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(WORDS) << 2;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_DECERR = 2'b11
  } axi_mst_resp_t;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  logic [DATA_W-1:0] mem [WORDS];

  function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a - BASE_ADDR} < MEM_BYTES);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
  endfunction

  // ---------------- read side ----------------
  rd_state_t             r_state, r_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx_q, r_idx_now;
  logic                  r_hit_q, r_hit_now;
  logic                  ar_fire, r_fire, r_sample;
  logic [DATA_W-1:0]     r_data_q;
  axi_mst_resp_t         r_resp_q;

  assign ar_fire   = (r_state == R_IDLE) && bus.ar_valid;
  assign r_fire    = (r_state == R_RESP) && bus.r_ready;
  // With zero latency the sample edge is the AR edge, so use the live address.
  assign r_idx_now = (r_state == R_IDLE) ? addr_idx(bus.ar_addr) : r_idx_q;
  assign r_hit_now = (r_state == R_IDLE) ? addr_hit(bus.ar_addr) : r_hit_q;
  assign r_sample  = (r_next == R_RESP) && (r_state != R_RESP);

  // Read next-state: wait out RD_LAT cycles, then hold the response until taken
  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_fire) r_next = (RD_LAT == 0) ? R_RESP : R_WAIT;
      R_WAIT:  if (r_cnt == CNT_W'(1)) r_next = R_RESP;
      R_RESP:  if (r_fire) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read state, latency counter, captured address and registered response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= R_IDLE;
      r_cnt    <= '0;
      r_idx_q  <= '0;
      r_hit_q  <= 1'b0;
      r_data_q <= '0;
      r_resp_q <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_fire) begin
        r_cnt   <= CNT_W'(RD_LAT);
        r_idx_q <= addr_idx(bus.ar_addr);
        r_hit_q <= addr_hit(bus.ar_addr);
      end else if ((r_state == R_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (r_sample) begin
        r_data_q <= r_hit_now ? mem[r_idx_now] : '0;
        r_resp_q <= r_hit_now ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  assign bus.ar_ready = (r_state == R_IDLE);
  assign bus.r_valid  = (r_state == R_RESP);
  assign bus.r_data   = r_data_q;
  assign bus.r_resp   = r_resp_q;

  // ---------------- write side ----------------
  wr_state_t             w_state, w_next;
  logic [CNT_W-1:0]      w_cnt;
  logic                  aw_got, w_got;
  logic [DEPTH_LOG2-1:0] aw_idx_q, c_idx;
  logic                  aw_hit_q, c_hit;
  logic [DATA_W-1:0]     w_data_q, c_data;
  logic [STRB_W-1:0]     w_strb_q, c_strb;
  logic                  aw_fire, w_fire, b_fire, w_both, w_enter_resp;
  axi_mst_resp_t         b_resp_q;

  assign aw_fire      = (w_state == W_IDLE) && !aw_got && bus.aw_valid;
  assign w_fire       = (w_state == W_IDLE) && !w_got && bus.w_valid;
  assign b_fire       = (w_state == W_RESP) && bus.b_ready;
  assign w_both       = (w_state == W_IDLE) && (aw_got || aw_fire) && (w_got || w_fire);
  // A channel captured this very cycle is not yet in its register.
  assign c_idx        = aw_got ? aw_idx_q : addr_idx(bus.aw_addr);
  assign c_hit        = aw_got ? aw_hit_q : addr_hit(bus.aw_addr);
  assign c_data       = w_got ? w_data_q : bus.w_data;
  assign c_strb       = w_got ? w_strb_q : bus.w_strb;
  assign w_enter_resp = (w_next == W_RESP) && (w_state != W_RESP);

  // Write next-state: collect AW and W, wait out WR_LAT, hold B until taken
  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (w_both) w_next = (WR_LAT == 0) ? W_RESP : W_WAIT;
      W_WAIT:  if (w_cnt == CNT_W'(1)) w_next = W_RESP;
      W_RESP:  if (b_fire) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write state, per-channel capture flags/registers and the B response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state  <= W_IDLE;
      w_cnt    <= '0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      aw_idx_q <= '0;
      aw_hit_q <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      b_resp_q <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (aw_fire) begin
        aw_got   <= 1'b1;
        aw_idx_q <= addr_idx(bus.aw_addr);
        aw_hit_q <= addr_hit(bus.aw_addr);
      end
      if (w_fire) begin
        w_got    <= 1'b1;
        w_data_q <= bus.w_data;
        w_strb_q <= bus.w_strb;
      end
      if (w_both) begin
        w_cnt <= CNT_W'(WR_LAT);
      end else if ((w_state == W_WAIT) && (w_cnt != '0)) begin
        w_cnt <= w_cnt - CNT_W'(1);
      end
      if (w_enter_resp) begin
        b_resp_q <= c_hit ? RESP_OKAY : RESP_DECERR;
      end
      if (b_fire) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  end

  // SRAM commit on the edge entering W_RESP; reset on that edge cancels it
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_enter_resp && c_hit) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (c_strb[i]) mem[c_idx][8*i +: 8] <= c_data[8*i +: 8];
      end
    end
  end

  assign bus.aw_ready = (w_state == W_IDLE) && !aw_got;
  assign bus.w_ready  = (w_state == W_IDLE) && !w_got;
  assign bus.b_valid  = (w_state == W_RESP);
  assign bus.b_resp   = b_resp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: table-driven, hand-written and randomized checks of the
// AXI4-Lite SRAM responder against constants and a simple word-array model.
module tb_axi_sram_slave;

  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 2;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] LIMIT  = 32'h8000_4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  axi_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_sram_slave #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(12), .BASE_ADDR(BASE),
    .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          w_gap;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [16];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one write; AW asserted at cycle aw_gap, W at cycle w_gap, B taken at once.
  // lat counts from the cycle the later channel handshakes to the first b_valid.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_gap, input int w_gap,
                          output logic [1:0] resp, output int lat, output bit ready_err);
    bit aw_done, w_done, got_b;
    int t_cap, cyc;
    aw_done = 0; w_done = 0; got_b = 0; t_cap = -1; cyc = 0;
    resp = '0; lat = -1; ready_err = 0;
    bus.aw_addr = addr; bus.w_data = data; bus.w_strb = strb; bus.b_ready = 1'b1;
    while (!got_b && cyc < 64) begin
      if (aw_done && bus.aw_ready) ready_err = 1;
      if (w_done && bus.w_ready) ready_err = 1;
      if (cyc == aw_gap) bus.aw_valid = 1'b1;
      if (cyc == w_gap) bus.w_valid = 1'b1;
      if (bus.b_valid) begin
        got_b = 1; resp = bus.b_resp; lat = cyc - t_cap;
      end
      if (bus.aw_valid && bus.aw_ready) aw_done = 1;
      if (bus.w_valid && bus.w_ready) w_done = 1;
      if (aw_done && w_done && t_cap < 0) t_cap = cyc;
      tick();
      cyc++;
      if (aw_done) bus.aw_valid = 1'b0;
      if (w_done) bus.w_valid = 1'b0;
    end
    bus.b_ready = 1'b0; bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    checkOutput("write_b_seen", 32'(got_b), 32'd1);
  endtask

  // Drive one read, holding r_ready low for 'hold' cycles after r_valid rises.
  task automatic do_read(input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp, output int lat,
                         output bit stable_err, output bit arready_err);
    int  t_hs, first_v, cyc;
    bit  done;
    t_hs = -1; first_v = -1; cyc = 0; done = 0;
    data = '0; resp = '0; lat = -1; stable_err = 0; arready_err = 0;
    bus.ar_addr = addr; bus.ar_valid = 1'b1; bus.r_ready = 1'b0;
    while (!done && cyc < 64) begin
      if (t_hs >= 0 && bus.ar_ready) arready_err = 1;
      if (t_hs < 0 && bus.ar_valid && bus.ar_ready) t_hs = cyc;
      if (bus.r_valid) begin
        if (first_v < 0) begin
          first_v = cyc; data = bus.r_data; resp = bus.r_resp;
        end else if (bus.r_data !== data || bus.r_resp !== resp) begin
          stable_err = 1;
        end
        if (cyc - first_v >= hold) begin
          bus.r_ready = 1'b1; done = 1;
        end
      end
      tick();
      cyc++;
      if (t_hs >= 0) bus.ar_valid = 1'b0;
    end
    bus.r_ready = 1'b0; bus.ar_valid = 1'b0;
    lat = (first_v >= 0 && t_hs >= 0) ? first_v - t_hs : -1;
    checkOutput("read_r_seen", 32'(done), 32'd1);
  endtask

  // Apply one table vector and compare against its expected fields
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    bit          e1, e2;
    if (v.is_write) begin
      do_write(v.addr, v.data, v.strb, 0, v.w_gap, r, lat, e1);
      checkOutput($sformatf("vec%0d_b_resp", idx), 32'(r), 32'(v.exp_resp));
      checkOutput($sformatf("vec%0d_b_lat", idx), 32'(lat), 32'(1 + WR_LAT));
      checkOutput($sformatf("vec%0d_ready_drop", idx), 32'(e1), 32'd0);
    end else begin
      do_read(v.addr, 0, d, r, lat, e1, e2);
      checkOutput($sformatf("vec%0d_r_data", idx), d, v.exp_data);
      checkOutput($sformatf("vec%0d_r_resp", idx), 32'(r), 32'(v.exp_resp));
      checkOutput($sformatf("vec%0d_r_lat", idx), 32'(lat), 32'(1 + RD_LAT));
    end
  endtask

  task automatic check_idle(input string tag);
    checkOutput({tag, "_ar_ready"}, 32'(bus.ar_ready), 32'd1);
    checkOutput({tag, "_aw_ready"}, 32'(bus.aw_ready), 32'd1);
    checkOutput({tag, "_w_ready"},  32'(bus.w_ready),  32'd1);
    checkOutput({tag, "_r_valid"},  32'(bus.r_valid),  32'd0);
    checkOutput({tag, "_b_valid"},  32'(bus.b_valid),  32'd0);
    checkOutput({tag, "_r_data"},   bus.r_data,        32'd0);
    checkOutput({tag, "_r_resp"},   32'(bus.r_resp),   32'd0);
    checkOutput({tag, "_b_resp"},   32'(bus.b_resp),   32'd0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    logic [31:0] d, addr, wd;
    logic [1:0]  r, exp_r;
    logic [3:0]  st;
    int          lat, lat2, k;
    bit          e1, e2, in_rng;
    logic [31:0] model [16];
    logic [31:0] oob [6];

    bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.r_ready = 1'b0;
    bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.w_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.b_ready = 1'b0;

    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2, 32'h0,         2'b00};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 2'b00};
    vecs[2]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'h5, 0, 32'h0,         2'b00};
    vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 0, 32'hDE22_BE44, 2'b00};
    vecs[4]  = '{1'b1, 32'h8000_0000, 32'h0102_0304, 4'hF, 1, 32'h0,         2'b00};
    vecs[5]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 0, 32'h0,         2'b11};
    vecs[6]  = '{1'b1, 32'h9000_0000, 32'h5555_5555, 4'hF, 0, 32'h0,         2'b11};
    vecs[7]  = '{1'b1, 32'h8000_4000, 32'h6666_6666, 4'hF, 0, 32'h0,         2'b11};
    vecs[8]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 0, 32'h0102_0304, 2'b00};
    vecs[9]  = '{1'b0, 32'h8000_0013, 32'h0,         4'h0, 0, 32'hDE22_BE44, 2'b00};
    vecs[10] = '{1'b1, 32'h8000_3FFC, 32'hAABB_CCDD, 4'hF, 3, 32'h0,         2'b00};
    vecs[11] = '{1'b0, 32'h8000_3FFE, 32'h0,         4'h0, 0, 32'hAABB_CCDD, 2'b00};
    vecs[12] = '{1'b0, 32'h8000_4000, 32'h0,         4'h0, 0, 32'h0,         2'b11};
    vecs[13] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 0, 32'h0,         2'b11};
    vecs[14] = '{1'b1, 32'h8000_0010, 32'hF00D_CAFE, 4'h0, 0, 32'h0,         2'b00};
    vecs[15] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 0, 32'hDE22_BE44, 2'b00};

    repeat (3) tick();
    rst = 1'b0;
    check_idle("reset");

    $display("[TB] table vectors");
    for (int i = 0; i < 16; i++) applyStimulus(vecs[i], i);

    $display("[TB] back-pressure on R");
    do_read(32'h8000_0010, 5, d, r, lat, e1, e2);
    checkOutput("hold_r_data", d, 32'hDE22_BE44);
    checkOutput("hold_r_resp", 32'(r), 32'd0);
    checkOutput("hold_r_lat", 32'(lat), 32'(1 + RD_LAT));
    checkOutput("hold_stable", 32'(e1), 32'd0);
    checkOutput("hold_ar_ready_low", 32'(e2), 32'd0);
    checkOutput("hold_ar_ready_after", 32'(bus.ar_ready), 32'd1);
    do_read(32'h8000_0000, 0, d, r, lat, e1, e2);
    checkOutput("back2back_r_data", d, 32'h0102_0304);
    checkOutput("back2back_r_lat", 32'(lat), 32'(1 + RD_LAT));

    $display("[TB] read/write collision");
    do_write(32'h8000_0020, 32'hA5A5_A5A5, 4'hF, 0, 0, r, lat, e1);
    fork
      do_write(32'h8000_0020, 32'h5A5A_1234, 4'hF, 0, 0, r, lat, e1);
      do_read(32'h8000_0020, 0, d, exp_r, lat2, e1, e2);
    join
    checkOutput("collide_old_data", d, 32'hA5A5_A5A5);
    checkOutput("collide_b_resp", 32'(r), 32'd0);
    do_read(32'h8000_0020, 0, d, r, lat, e1, e2);
    checkOutput("collide_new_data", d, 32'h5A5A_1234);

    $display("[TB] reset during WAIT states");
    do_write(32'h8000_0040, 32'h1234_5678, 4'hF, 0, 0, r, lat, e1);
    bus.aw_addr = 32'h8000_0040; bus.w_data = 32'hCAFE_F00D; bus.w_strb = 4'hF;
    bus.ar_addr = 32'h8000_0040;
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.ar_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst");
    do_read(32'h8000_0040, 0, d, r, lat, e1, e2);
    checkOutput("midrst_word_kept", d, 32'h1234_5678);

    $display("[TB] randomized traffic");
    oob[0] = 32'h7FFF_FFFC; oob[1] = 32'h8000_4000; oob[2] = 32'h8000_4080;
    oob[3] = 32'h0000_0080; oob[4] = 32'hFFFF_FFFC; oob[5] = 32'h9000_0084;
    for (int j = 0; j < 16; j++) begin
      wd = $urandom;
      do_write(BASE + 32'((32 + j) * 4), wd, 4'hF, 0, 0, r, lat, e1);
      checkOutput("rnd_init_resp", 32'(r), 32'd0);
      model[j] = wd;
    end
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0)
        addr = oob[$urandom_range(0, 5)];
      else
        addr = BASE + 32'((32 + $urandom_range(0, 15)) * 4) + 32'($urandom_range(0, 3));
      in_rng = (addr >= BASE) && (addr < LIMIT);
      k = in_rng ? int'((addr - BASE) / 4) - 32 : 0;
      exp_r = in_rng ? 2'b00 : 2'b11;
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        st = 4'($urandom_range(0, 15));
        do_write(addr, wd, st, $urandom_range(0, 3), $urandom_range(0, 3), r, lat, e1);
        checkOutput($sformatf("rnd%0d_b_resp", n), 32'(r), 32'(exp_r));
        checkOutput($sformatf("rnd%0d_b_lat", n), 32'(lat), 32'(1 + WR_LAT));
        checkOutput($sformatf("rnd%0d_ready_drop", n), 32'(e1), 32'd0);
        if (in_rng) begin
          for (int b = 0; b < 4; b++)
            if (st[b]) model[k][8*b +: 8] = wd[8*b +: 8];
        end
      end else begin
        do_read(addr, $urandom_range(0, 3), d, r, lat, e1, e2);
        checkOutput($sformatf("rnd%0d_r_data", n), d, in_rng ? model[k] : 32'h0);
        checkOutput($sformatf("rnd%0d_r_resp", n), 32'(r), 32'(exp_r));
        checkOutput($sformatf("rnd%0d_r_lat", n), 32'(lat), 32'(1 + RD_LAT));
        checkOutput($sformatf("rnd%0d_r_stable", n), 32'(e1), 32'd0);
      end
    end
    for (int j = 0; j < 16; j++) begin
      do_read(BASE + 32'((32 + j) * 4), 0, d, r, lat, e1, e2);
      checkOutput($sformatf("rnd_final_word%0d", j), d, model[j]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
